// File: rtl/vis_pkg.sv
// Shared definitions for the visibility byte serialiser: FSM states, default sync byte, bytes-per-word.
// VIS_SERIALISER_CHECKSUM_EN adds the CSUM state.
package vis_pkg;

  localparam int unsigned VIS_ACCUM_DEFAULT  = 32;
  localparam logic [7:0]  VIS_SYNC_DEFAULT   = 8'hA5;
  localparam int unsigned VIS_BYTES_PER_WORD = 2 * VIS_ACCUM_DEFAULT / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_DATA
`ifdef VIS_SERIALISER_CHECKSUM_EN
    , S_CSUM
`endif
  } vis_state_e;

  // Bytes emitted per {revis, imvis} word for a given component width.
  function automatic int unsigned bytes_per_word(input int unsigned accum);
    return 2 * accum / 8;
  endfunction

endpackage

// File: rtl/vis_serialiser.sv
// Serialises {revis, imvis} visibility words into a framed byte stream (sync, sequence, data[, checksum]).
// Define VIS_SERIALISER_CHECKSUM_EN to append a mod-256 checksum byte to each frame.
module vis_serialiser
  import vis_pkg::*;
#(
  parameter int unsigned ACCUM = VIS_ACCUM_DEFAULT,
  parameter logic [7:0]  SYNC  = VIS_SYNC_DEFAULT
) (
  input  logic             bus_clock,
  input  logic             bus_rst_n,
  input  logic [ACCUM-1:0] vis_revis_i,
  input  logic [ACCUM-1:0] vis_imvis_i,
  input  logic             vis_valid_i,
  output logic             vis_ready_o,
  input  logic             vis_last_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [7:0]       m_tdata_o
);

  localparam int unsigned NBYTES = bytes_per_word(ACCUM);
  localparam int unsigned WORD_W = 2 * ACCUM;
  localparam int unsigned IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  vis_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic              sof_q, sof_d;
  logic [7:0]        seq_q, seq_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic              ready_q, ready_d;
`ifdef VIS_SERIALISER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic             accept;
  logic             xfer;
  logic [IDX_W-1:0] idx_nxt;
  logic [WORD_W-1:0] word_in;

  assign accept  = vis_valid_i && ready_q;
  assign xfer    = tvalid_q && m_tready_i;
  assign idx_nxt = idx_q + IDX_W'(1);
  assign word_in = {vis_revis_i, vis_imvis_i};

  // word_q is a shift register: its top byte is always the next DATA byte to present.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    sof_d   = sof_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
`ifdef VIS_SERIALISER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_d  = vis_last_i;
          sof_d   = 1'b0;
          idx_d   = '0;
          tlast_d = 1'b0;
          if (sof_q) begin
            state_d = S_SYNC;
            word_d  = word_in;
            tdata_d = SYNC;
`ifdef VIS_SERIALISER_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
          end else begin
            state_d = S_DATA;
            word_d  = word_in << 8;
            tdata_d = word_in[WORD_W-1 -: 8];
          end
        end
      end
      S_SYNC: begin
        if (xfer) begin
          state_d = S_SEQ;
          tdata_d = seq_q;
        end
      end
      S_SEQ: begin
        if (xfer) begin
          state_d = S_DATA;
          tdata_d = word_q[WORD_W-1 -: 8];
          word_d  = word_q << 8;
        end
      end
      S_DATA: begin
        if (xfer) begin
`ifdef VIS_SERIALISER_CHECKSUM_EN
          csum_d = csum_q + tdata_q;
`endif
          if (idx_q == IDX_LAST) begin
            tlast_d = 1'b0;
            state_d = S_IDLE;
            if (last_q) begin
`ifdef VIS_SERIALISER_CHECKSUM_EN
              state_d = S_CSUM;
              tdata_d = csum_q + tdata_q;
              tlast_d = 1'b1;
`else
              seq_d   = seq_q + 8'd1;
              sof_d   = 1'b1;
`endif
            end
          end else begin
            idx_d   = idx_nxt;
            tdata_d = word_q[WORD_W-1 -: 8];
            word_d  = word_q << 8;
`ifdef VIS_SERIALISER_CHECKSUM_EN
            tlast_d = 1'b0;
`else
            tlast_d = last_q && (idx_nxt == IDX_LAST);
`endif
          end
        end
      end
`ifdef VIS_SERIALISER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d = S_IDLE;
          tlast_d = 1'b0;
          seq_d   = seq_q + 8'd1;
          sof_d   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    tvalid_d = (state_d != S_IDLE);
    ready_d  = (state_d == S_IDLE);
  end

  // Handshake flags are registered copies of the next-state decode so reset can force them low.
  always_ff @(posedge bus_clock) begin
    if (!bus_rst_n) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      last_q   <= 1'b0;
      sof_q    <= 1'b1;
      seq_q    <= 8'h00;
      idx_q    <= '0;
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b0;
`ifdef VIS_SERIALISER_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      last_q   <= last_d;
      sof_q    <= sof_d;
      seq_q    <= seq_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      ready_q  <= ready_d;
`ifdef VIS_SERIALISER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign vis_ready_o = ready_q;
  assign m_tvalid_o  = tvalid_q;
  assign m_tlast_o   = tlast_q;
  assign m_tdata_o   = tdata_q;

endmodule

// File: tb/tb_vis_serialiser.sv
// Scoreboard bench for vis_serialiser: a frame-level byte model feeds an expected queue, a monitor checks the stream.
module tb_vis_serialiser;

  localparam int unsigned ACCUM = 32;
  localparam int unsigned NB    = 2 * ACCUM / 8;
`ifdef VIS_SERIALISER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic             bus_clock = 1'b0;
  logic             bus_rst_n;
  logic [ACCUM-1:0] vis_revis_i;
  logic [ACCUM-1:0] vis_imvis_i;
  logic             vis_valid_i;
  logic             vis_ready_o;
  logic             vis_last_i;
  logic             m_tvalid_o;
  logic             m_tready_i;
  logic             m_tlast_o;
  logic [7:0]       m_tdata_o;

  vis_serialiser #(.ACCUM(ACCUM), .SYNC(8'hA5)) dut (
    .bus_clock  (bus_clock),
    .bus_rst_n  (bus_rst_n),
    .vis_revis_i(vis_revis_i),
    .vis_imvis_i(vis_imvis_i),
    .vis_valid_i(vis_valid_i),
    .vis_ready_o(vis_ready_o),
    .vis_last_i (vis_last_i),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .m_tlast_o  (m_tlast_o),
    .m_tdata_o  (m_tdata_o)
  );

  always #5 bus_clock = ~bus_clock;

  int checks = 0;
  int errors = 0;

  // Expected stream entries: {tlast, tdata}
  logic [8:0] exp_q[$];
  logic [7:0] m_seq  = 8'h00;
  bit         m_sof  = 1'b1;
  logic [7:0] m_csum = 8'h00;
  int         rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 driven by stimulus

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: header on first word, bytes MSB first, optional checksum, sequence bumps per frame.
  function automatic void model_word(input logic [ACCUM-1:0] re, input logic [ACCUM-1:0] im,
                                     input bit last);
    logic [2*ACCUM-1:0] w;
    logic [7:0]         b;
    if (m_sof) begin
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b0, m_seq});
      m_csum = 8'h00;
      m_sof  = 1'b0;
    end
    w = {re, im};
    for (int i = 0; i < int'(NB); i++) begin
      b = 8'(w >> (8 * (int'(NB) - 1 - i)));
      m_csum = m_csum + b;
      exp_q.push_back({(last && !CSUM_EN && i == int'(NB) - 1), b});
    end
    if (last) begin
      if (CSUM_EN) exp_q.push_back({1'b1, m_csum});
      m_seq = m_seq + 8'd1;
      m_sof = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_seq  = 8'h00;
    m_sof  = 1'b1;
    m_csum = 8'h00;
  endfunction

  task automatic send_word(input logic [ACCUM-1:0] re, input logic [ACCUM-1:0] im, input bit last);
    bit got;
    vis_revis_i = re;
    vis_imvis_i = im;
    vis_last_i  = last;
    vis_valid_i = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge bus_clock);
      if (vis_ready_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no vis_ready_o in 2000 cycles, required one");
    end else begin
      model_word(re, im, last);
    end
    @(posedge bus_clock);
    #1;
  endtask

  task automatic idle(input int n);
    vis_valid_i = 1'b0;
    repeat (n) @(posedge bus_clock);
    #1;
  endtask

  task automatic drain();
    vis_valid_i = 1'b0;
    for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(negedge bus_clock);
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    @(posedge bus_clock);
    #1;
  endtask

  // Output ready pattern, changed just after each rising edge.
  always @(posedge bus_clock) begin
    #1;
    case (rdy_mode)
      0: m_tready_i = 1'b1;
      1: m_tready_i = ~m_tready_i;
      2: m_tready_i = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: pops the scoreboard on each transfer, checks stall stability and input handshake rules.
  logic [8:0] stall_val;
  bit         stall_pending = 1'b0;
  bit         acc_prev      = 1'b0;
  always @(negedge bus_clock) begin
    logic [8:0] e;
    if (!bus_rst_n) begin
      stall_pending = 1'b0;
      acc_prev      = 1'b0;
    end else begin
      if (vis_ready_o) begin
        checks++;
        if (m_tvalid_o) begin
          errors++;
          $display("FAIL ready_while_emitting: got vis_ready_o=1 with m_tvalid_o=1, required ready only when idle");
        end
      end
      if (acc_prev) begin
        checks++;
        if (vis_ready_o) begin
          errors++;
          $display("FAIL ready_after_accept: got vis_ready_o=1 the cycle after acceptance, required 0");
        end
      end
      if (stall_pending) begin
        checks++;
        if ({m_tlast_o, m_tdata_o} !== stall_val || !m_tvalid_o) begin
          errors++;
          $display("FAIL stall_stable: got valid=%0b last/data=%03h, required valid=1 last/data=%03h",
                   m_tvalid_o, {m_tlast_o, m_tdata_o}, stall_val);
        end
      end
      if (m_tvalid_o && m_tready_i) begin
        stall_pending = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got byte %02h last=%0b, required no output", m_tdata_o, m_tlast_o);
        end else begin
          e = exp_q.pop_front();
          if ({m_tlast_o, m_tdata_o} !== e) begin
            errors++;
            $display("FAIL stream_byte: got data=%02h last=%0b, required data=%02h last=%0b",
                     m_tdata_o, m_tlast_o, e[7:0], e[8]);
          end
        end
      end else if (m_tvalid_o) begin
        stall_pending = 1'b1;
        stall_val     = {m_tlast_o, m_tdata_o};
      end else begin
        stall_pending = 1'b0;
      end
      acc_prev = vis_valid_i && vis_ready_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(vis_ready_o), 32'd0);
    chk({tag, "_tvalid"}, 32'(m_tvalid_o), 32'd0);
    chk({tag, "_tlast"}, 32'(m_tlast_o), 32'd0);
    chk({tag, "_tdata"}, 32'(m_tdata_o), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    bus_rst_n   = 1'b0;
    vis_valid_i = 1'b0;
    vis_last_i  = 1'b0;
    vis_revis_i = '0;
    vis_imvis_i = '0;
    m_tready_i  = 1'b1;

    repeat (3) @(posedge bus_clock);
    @(negedge bus_clock);
    check_reset_outputs("por");
    @(posedge bus_clock);
    #1 bus_rst_n = 1'b1;
    @(negedge bus_clock);
    chk("ready_before_edge", 32'(vis_ready_o), 32'd0);
    @(negedge bus_clock);
    chk("ready_first_cycle", 32'(vis_ready_o), 32'd1);
    @(posedge bus_clock);
    #1;

    // Directed single-word frames
    rdy_mode = 0;
    send_word(32'h01020304, 32'h05060708, 1'b1);
    idle(2);
    send_word(32'hFFFFFFFF, 32'h00000000, 1'b1);
    drain();

    // Two-word frame under alternating ready
    rdy_mode = 1;
    send_word(32'h11223344, 32'h55667788, 1'b0);
    send_word(32'h99AABBCC, 32'hDDEEFF00, 1'b1);
    drain();

    // Random multi-word frames with random backpressure and input gaps
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        send_word(ACCUM'($urandom), ACCUM'($urandom), (w == nw - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    drain();

    // Reset while the fourth DATA byte is presented
    rdy_mode   = 3;
    m_tready_i = 1'b0;
    send_word(ACCUM'($urandom), ACCUM'($urandom), 1'b1);
    vis_valid_i = 1'b0;
    m_tready_i  = 1'b1;
    repeat (5) @(posedge bus_clock);
    #1 m_tready_i = 1'b0;
    chk("pre_reset_remaining", 32'(exp_q.size()), 32'(NB - 3 + 32'(CSUM_EN)));
    bus_rst_n = 1'b0;
    model_reset();
    @(posedge bus_clock);
    @(negedge bus_clock);
    check_reset_outputs("midrst");
    @(posedge bus_clock);
    #1 bus_rst_n = 1'b1;
    @(negedge bus_clock);
    chk("midrst_ready_before_edge", 32'(vis_ready_o), 32'd0);
    @(negedge bus_clock);
    chk("midrst_ready_first_cycle", 32'(vis_ready_o), 32'd1);
    chk("midrst_no_output", 32'(m_tvalid_o), 32'd0);
    @(posedge bus_clock);
    #1;

    // 257 back-to-back single-word frames: sequence 00..FF then wraps to 00
    rdy_mode = 0;
    for (int f = 0; f < 257; f++) begin
      send_word(ACCUM'($urandom), ACCUM'($urandom), 1'b1);
    end
    drain();
    chk("final_model_seq", 32'(m_seq), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
